// File: rtl/instr_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl
// Description : Instruction fetch controller. Issues word reads to a
//               synchronous instruction memory (one-cycle read latency).
//               Buffers responses in a 2-entry output FIFO toward decode.
//               Handles branch/jump redirects with flush, and halts on a
//               misaligned redirect target.
// Ports       : clk                - single clock, rising edge
//               rst_n              - synchronous active-low reset
//               fetch_en_in        - permit new fetch requests
//               redirect_in        - flush and restart at redirect_pc_in
//               redirect_pc_in     - redirect target byte address
//               mem_addr_out       - byte address to memory (PC low bits)
//               mem_rd_en_out      - high in every cycle a fetch issues
//               mem_data_in        - read data, valid one cycle after issue
//               instr_valid_out    - instr_out/instr_pc_out hold an instr
//               instr_ready_in     - decode accepts the instruction
//               instr_out          - fetched instruction (FIFO head)
//               instr_pc_out       - byte address of instr_out
//               misaligned_err_out - sticky misaligned-redirect flag
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
  parameter int              ARCH      = 32,
  parameter int              RAM_DEPTH = 4096,
  parameter logic [ARCH-1:0] RESET_PC  = '0,
  localparam int             ADDR_W    = $clog2(RAM_DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en_in,
  input  logic              redirect_in,
  input  logic [ARCH-1:0]   redirect_pc_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_rd_en_out,
  input  logic [ARCH-1:0]   mem_data_in,
  output logic              instr_valid_out,
  input  logic              instr_ready_in,
  output logic [ARCH-1:0]   instr_out,
  output logic [ARCH-1:0]   instr_pc_out,
  output logic              misaligned_err_out
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_HALT  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [ARCH-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [ARCH-1:0] inflight_pc_q, inflight_pc_d;
  logic            err_q, err_d;

  // 2-entry output FIFO: instruction word and its PC per slot
  logic [ARCH-1:0] fifo_instr_q [2];
  logic [ARCH-1:0] fifo_pc_q    [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;

  logic            w_misaligned;
  logic            w_accept;
  logic            w_pop;
  logic            w_push;
  logic [2:0]      w_occ;
  logic [2:0]      w_limit;
  logic            w_issue;

  assign w_misaligned = redirect_in & (|redirect_pc_in[1:0]);
  assign w_accept     = instr_valid_out & instr_ready_in;

  // Redirect overrides both FIFO ports: the flush wins over any push/pop.
  assign w_pop  = w_accept & ~redirect_in;
  assign w_push = inflight_q & ~redirect_in;

  // Issue only if the FIFO can absorb this response once the current
  // in-flight one lands: count + inflight - pop < 2, rearranged to avoid
  // negative intermediates.
  assign w_occ   = {1'b0, count_q} + {2'b00, inflight_q};
  assign w_limit = 3'd2 + {2'b00, w_accept};
  assign w_issue = rst_n & (state_q == c_FETCH) & ~redirect_in & (w_occ < w_limit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (fetch_en_in)  state_d = c_FETCH;
      c_FETCH: if (!fetch_en_in) state_d = c_IDLE;
      c_HALT:  state_d = c_HALT;
      default: state_d = c_IDLE;
    endcase
    if (w_misaligned) state_d = c_HALT;
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = w_issue;
    inflight_pc_d = inflight_pc_q;
    err_d         = err_q | w_misaligned;
    if (redirect_in) begin
      // Low bits are dropped so the PC stays word aligned even when the
      // target was misaligned (the block halts in that case anyway).
      pc_d = {redirect_pc_in[ARCH-1:2], 2'b00};
    end else if (w_issue) begin
      pc_d          = pc_q + ARCH'(4);
      inflight_pc_d = pc_q;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_in) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (w_push) wr_ptr_d = ~wr_ptr_q;
      if (w_pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= c_IDLE;
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_pc_q   <= '0;
      err_q           <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      fifo_instr_q[0] <= '0;
      fifo_instr_q[1] <= '0;
      fifo_pc_q[0]    <= '0;
      fifo_pc_q[1]    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      err_q         <= err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      if (w_push) begin
        fifo_instr_q[wr_ptr_q] <= mem_data_in;
        fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
      end
    end
  end

  assign mem_addr_out       = pc_q[ADDR_W-1:0];
  assign mem_rd_en_out      = w_issue;
  assign instr_valid_out    = (count_q != 2'd0);
  assign instr_out          = fifo_instr_q[rd_ptr_q];
  assign instr_pc_out       = fifo_pc_q[rd_ptr_q];
  assign misaligned_err_out = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_ctrl
// Description : Directed self-checking bench for instr_fetch_ctrl. The
//               memory model returns word n = n, one cycle after the read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

  localparam int ARCH      = 32;
  localparam int RAM_DEPTH = 4096;
  localparam int ADDR_W    = $clog2(RAM_DEPTH) + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_en;
  logic              redirect;
  logic [ARCH-1:0]   redirect_pc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [ARCH-1:0]   mem_data = '0;
  logic              instr_valid;
  logic              instr_ready;
  logic [ARCH-1:0]   instr;
  logic [ARCH-1:0]   instr_pc;
  logic              mis_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .ARCH      (ARCH),
    .RAM_DEPTH (RAM_DEPTH),
    .RESET_PC  ('0)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fetch_en_in        (fetch_en),
    .redirect_in        (redirect),
    .redirect_pc_in     (redirect_pc),
    .mem_addr_out       (mem_addr),
    .mem_rd_en_out      (mem_rd_en),
    .mem_data_in        (mem_data),
    .instr_valid_out    (instr_valid),
    .instr_ready_in     (instr_ready),
    .instr_out          (instr),
    .instr_pc_out       (instr_pc),
    .misaligned_err_out (mis_err)
  );

  // Synchronous instruction memory: word n holds value n. Unread cycles
  // return a marker so a push of an unrequested word is visible.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= ARCH'(mem_addr >> 2);
    else           mem_data <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled 2 time units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    fetch_en    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    #2;
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_ipc", instr_pc, 0);
    check("rst_err", mis_err, 0);
    check("rst_rden", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);

    // ---------------- startup and streaming ----------------
    tick(); rst_n = 1'b1; instr_ready = 1'b1; #2;              // t0
    check("t0_rden", mem_rd_en, 0);
    check("t0_valid", instr_valid, 0);
    tick(); #2;                                                // t0+1
    check("t1_rden", mem_rd_en, 1);
    check("t1_addr", mem_addr, 0);
    check("t1_valid", instr_valid, 0);
    tick(); #2;                                                // t0+2
    check("t2_rden", mem_rd_en, 1);
    check("t2_addr", mem_addr, 4);
    check("t2_valid", instr_valid, 0);
    for (int k = 0; k < 6; k++) begin                          // t0+3+k
      tick(); #2;
      check("str_valid", instr_valid, 1);
      check("str_instr", instr, k);
      check("str_ipc", instr_pc, 4 * k);
      check("str_addr", mem_addr, 8 + 4 * k);
    end

    // ---------------- backpressure for 5 cycles ----------------
    tick(); instr_ready = 1'b0; #2;                            // S
    check("bp_valid", instr_valid, 1);
    check("bp_instr", instr, 6);
    check("bp_rden", mem_rd_en, 0);
    for (int i = 1; i < 5; i++) begin
      tick(); #2;
      check("bp_hold_instr", instr, 6);
      check("bp_hold_ipc", instr_pc, 24);
      check("bp_hold_rden", mem_rd_en, 0);
    end
    tick(); instr_ready = 1'b1; #2;                            // S+5
    check("bp_rel_instr", instr, 6);
    check("bp_rel_rden", mem_rd_en, 1);
    check("bp_rel_addr", mem_addr, 32);
    for (int j = 1; j < 5; j++) begin                          // S+6..S+9
      tick(); #2;
      check("bp_resume_valid", instr_valid, 1);
      check("bp_resume_instr", instr, 6 + j);
      check("bp_resume_ipc", instr_pc, 4 * (6 + j));
    end

    // ---------------- redirect to 0x40 ----------------
    // Head is instr 10 and the response for pc 44 is in flight; with ready
    // low it would have filled the FIFO. Both must be discarded.
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40; #1;
    check("rd_t_rden", mem_rd_en, 0);
    tick(); redirect = 1'b0; instr_ready = 1'b1; #2;           // t+1
    check("rd_t1_valid", instr_valid, 0);
    check("rd_t1_rden", mem_rd_en, 1);
    check("rd_t1_addr", mem_addr, 32'h40);
    tick(); #2;                                                // t+2
    check("rd_t2_valid", instr_valid, 0);
    check("rd_t2_addr", mem_addr, 32'h44);
    tick(); #2;                                                // t+3
    check("rd_t3_valid", instr_valid, 1);
    check("rd_t3_instr", instr, 32'h10);
    check("rd_t3_ipc", instr_pc, 32'h40);
    tick(); #2;                                                // t+4
    check("rd_t4_instr", instr, 32'h11);
    check("rd_t4_ipc", instr_pc, 32'h44);

    // ---------------- misaligned redirect to 0x42 ----------------
    tick(); redirect = 1'b1; redirect_pc = 32'h42; instr_ready = 1'b0; #2;
    check("mis_t_err", mis_err, 0);
    check("mis_t_rden", mem_rd_en, 0);
    tick(); redirect = 1'b0; instr_ready = 1'b1; #2;
    check("mis_t1_err", mis_err, 1);
    check("mis_t1_valid", instr_valid, 0);
    check("mis_t1_addr", mem_addr, 32'h40);
    for (int i = 0; i < 4; i++) begin
      tick(); #2;
      check("halt_rden", mem_rd_en, 0);
      check("halt_err", mis_err, 1);
      check("halt_valid", instr_valid, 0);
    end
    tick(); rst_n = 1'b0; #2;
    check("halt_err_pre_rst", mis_err, 1);

    // ---------------- restart, fill FIFO, reset with redirect ----------------
    tick(); rst_n = 1'b1; instr_ready = 1'b0; #2;              // t0'
    check("rst2_err", mis_err, 0);
    check("rst2_valid", instr_valid, 0);
    tick(); #2;                                                // t0'+1
    check("rst2_t1_rden", mem_rd_en, 1);
    check("rst2_t1_addr", mem_addr, 0);
    tick(); #2;                                                // t0'+2
    check("rst2_t2_rden", mem_rd_en, 1);
    check("rst2_t2_addr", mem_addr, 4);
    tick(); #2;                                                // t0'+3
    check("rst2_t3_valid", instr_valid, 1);
    check("rst2_t3_instr", instr, 0);
    check("rst2_t3_rden", mem_rd_en, 0);
    tick(); #2;                                                // t0'+4
    check("full_rden", mem_rd_en, 0);
    check("full_instr", instr, 0);
    tick(); rst_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h80; #2;
    check("full_rst_valid", instr_valid, 1);
    tick(); redirect = 1'b0; #2;
    check("rst3_valid", instr_valid, 0);
    check("rst3_instr", instr, 0);
    check("rst3_ipc", instr_pc, 0);
    check("rst3_err", mis_err, 0);
    check("rst3_rden", mem_rd_en, 0);
    check("rst3_addr", mem_addr, 0);

    // ---------------- PC wrap at 2^32 ----------------
    tick(); rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; instr_ready = 1'b1; #2;
    check("wr_q_rden", mem_rd_en, 0);
    tick(); redirect = 1'b0; #2;
    check("wr_q1_rden", mem_rd_en, 1);
    check("wr_q1_addr", mem_addr, 32'h3FF8);
    tick(); #2;
    check("wr_q2_addr", mem_addr, 32'h3FFC);
    tick(); #2;
    check("wr_q3_addr", mem_addr, 0);
    check("wr_q3_instr", instr, 32'hFFE);
    check("wr_q3_ipc", instr_pc, 32'hFFFF_FFF8);
    tick(); #2;
    check("wr_q4_instr", instr, 32'hFFF);
    check("wr_q4_ipc", instr_pc, 32'hFFFF_FFFC);

    // ---------------- fetch disable: in-flight lands, FIFO drains ----------------
    tick(); fetch_en = 1'b0; #2;                               // still in FETCH
    check("dis_instr", instr, 0);
    check("dis_ipc", instr_pc, 0);
    check("dis_rden", mem_rd_en, 1);
    tick(); #2;
    check("dis1_rden", mem_rd_en, 0);
    check("dis1_instr", instr, 1);
    check("dis1_ipc", instr_pc, 4);
    tick(); #2;
    check("dis2_instr", instr, 2);
    check("dis2_ipc", instr_pc, 8);
    tick(); #2;
    check("dis3_valid", instr_valid, 0);
    check("dis3_rden", mem_rd_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
